// File: rtl/imem_line_responder_pkg.sv
// Shared types and geometry for the imem line responder.
// Line/beat/group sizes, FSM state enum, line buffer struct.
package imem_line_responder_pkg;

  localparam int INSTR_FETCH_NUM = 4;
  localparam int GW         = 32 * INSTR_FETCH_NUM;
  localparam int LINE_WIDTH = 256;
  localparam int BMEM_WIDTH = 64;
  localparam int LINE_BEATS = LINE_WIDTH / BMEM_WIDTH;
  localparam int LOB        = $clog2(LINE_WIDTH / 8);
  localparam int GOB        = $clog2(GW / 8);
  localparam int NGROUPS    = LINE_WIDTH / GW;
  localparam int GSW        = $clog2(NGROUPS);
  localparam int BCW        = $clog2(LINE_BEATS);
  localparam int TAGW       = 32 - LOB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } imem_resp_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAGW-1:0]       tag;
    logic [LINE_WIDTH-1:0] data;
  } line_buf_t;

  function automatic logic [GW-1:0] group_sel(
    input logic [LINE_WIDTH-1:0] line,
    input logic [GSW-1:0]        g
  );
    return line[g*GW +: GW];
  endfunction

endpackage

// File: rtl/imem_line_responder_if.sv
// Fetch-side and bmem-side signal bundle of the line responder.
// slave: responder view; master: fetch stage + backing memory view.
interface imem_line_responder_if;
  import imem_line_responder_pkg::*;

  logic [31:0]           imem_addr;
  logic [3:0]            imem_rmask;
  logic                  imem_resp;
  logic [GW-1:0]         imem_rdata;
  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_ready;
  logic [31:0]           bmem_raddr;
  logic [BMEM_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport slave (
    input  imem_addr, imem_rmask,
    input  bmem_ready, bmem_raddr,
    input  bmem_rdata, bmem_rvalid,
    output imem_resp, imem_rdata,
    output bmem_addr, bmem_read
  );

  modport master (
    output imem_addr, imem_rmask,
    output bmem_ready, bmem_raddr,
    output bmem_rdata, bmem_rvalid,
    input  imem_resp, imem_rdata,
    input  bmem_addr, bmem_read
  );

endinterface

// File: rtl/imem_line_responder.sv
// One-line instruction buffer: hits return a fetch group per cycle,
// misses burst-refill the line from bmem. Ports: clk, rst (async low), bus.
module imem_line_responder
  import imem_line_responder_pkg::*;
(
  input logic             clk,
  input logic             rst,
  imem_line_responder_if.slave bus
);

  localparam logic [BCW-1:0] LAST = BCW'(LINE_BEATS - 1);

  imem_resp_state_t r_state;
  line_buf_t        r_line;
  logic [31:GOB]    r_req;
  logic [BCW-1:0]   r_cnt;
  logic             r_resp;
  logic [GW-1:0]    r_rdata;
  logic             r_bread;
  logic [31:0]      r_baddr;

  logic                  w_req;
  logic                  w_hit;
  logic                  w_beat;
  logic [LINE_WIDTH-1:0] w_fill;

  assign w_req = |bus.imem_rmask;
  assign w_hit = r_line.valid &&
    (bus.imem_addr[31:LOB] == r_line.tag);
  // raddr match filters stale bursts issued before a reset
  assign w_beat = bus.bmem_rvalid &&
    (bus.bmem_raddr == r_baddr);

  // line as it looks with the current beat merged in
  always_comb begin
    w_fill = r_line.data;
    w_fill[r_cnt*BMEM_WIDTH +: BMEM_WIDTH] =
      bus.bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_req   <= '0;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_bread <= 1'b0;
      r_baddr <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          if (w_req) begin
            r_req <= bus.imem_addr[31:GOB];
            if (w_hit) begin
              r_resp  <= 1'b1;
              r_rdata <= group_sel(r_line.data,
                bus.imem_addr[LOB-1:GOB]);
            end else begin
              r_state <= REQ;
              r_bread <= 1'b1;
              r_baddr <= {bus.imem_addr[31:LOB],
                {LOB{1'b0}}};
            end
          end
        end
        REQ: begin
          if (bus.bmem_ready) begin
            r_bread      <= 1'b0;
            r_state      <= FILL;
            r_cnt        <= '0;
            r_line.valid <= 1'b0;
          end
        end
        FILL: begin
          if (w_beat) begin
            r_line.data <= w_fill;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_line.tag   <= r_req[31:LOB];
              r_line.valid <= 1'b1;
              r_rdata <= group_sel(w_fill,
                r_req[LOB-1:GOB]);
              r_resp  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.imem_resp  = r_resp;
  assign bus.imem_rdata = r_rdata;
  assign bus.bmem_read  = r_bread;
  assign bus.bmem_addr  = r_baddr;

endmodule
